// File: rtl/rd_pkg.sv
// Shared types and helpers for the recursive-doubling (Kogge-Stone) adder.
// A KPG symbol encodes what a bit position does to an incoming carry:
// KILL forces 0, GEN forces 1, PROP passes the lower carry through.
// In the encoding, bit[1] is the resolved carry once no PROP remains.
package rd_pkg;

  typedef logic [1:0] kpg_t;

  localparam kpg_t KILL = 2'b00;
  localparam kpg_t PROP = 2'b01;
  localparam kpg_t GEN  = 2'b11;

  // Merge a span (hi) with the span directly below it (lo).
  function automatic kpg_t kpg_combine(input kpg_t hi, input kpg_t lo);
    kpg_t r;
    if (hi == PROP) begin
      r = lo;
    end else begin
      r = hi;
    end
    return r;
  endfunction

  // Classify a single bit pair.
  function automatic kpg_t kpg_encode(input logic ai, input logic bi);
    kpg_t r;
    if (ai & bi) begin
      r = GEN;
    end else if (ai ^ bi) begin
      r = PROP;
    end else begin
      r = KILL;
    end
    return r;
  endfunction

endpackage

// File: rtl/rd_kpg_level.sv
// One doubling level of the carry tree: each position at or above DIST
// merges with the position DIST below it. The result is registered together
// with the valid bit and the propagate vector, and everything holds while
// the pipeline is stalled.
module rd_kpg_level
  import rd_pkg::*;
#(
  parameter int N    = 17,
  parameter int DIST = 1,
  parameter int PW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_advance,
  input  logic              i_valid,
  input  logic [PW-1:0]     i_p,
  input  kpg_t [N-1:0]      i_kpg,
  output logic              o_valid,
  output logic [PW-1:0]     o_p,
  output kpg_t [N-1:0]      o_kpg
);

  kpg_t [N-1:0] w_kpg_nxt;

  // Positions below DIST have nothing DIST below them and pass unchanged.
  genvar j;
  for (j = 0; j < N; j++) begin : g_pos
    if (j >= DIST) begin : g_merge
      assign w_kpg_nxt[j] = kpg_combine(i_kpg[j], i_kpg[j-DIST]);
    end else begin : g_pass
      assign w_kpg_nxt[j] = i_kpg[j];
    end
  end

  // Level register: load from the previous level on advance, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_p     <= {PW{1'b0}};
      o_kpg   <= {N{KILL}};
    end else if (i_advance) begin
      o_valid <= i_valid;
      o_p     <= i_p;
      o_kpg   <= w_kpg_nxt;
    end
  end

endmodule

// File: rtl/rd_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
// Stage 0 encodes operands into WIDTH+1 KPG positions (position 0 carries
// the carry-in), LEVELS doubling levels resolve every carry, and the output
// stage forms sum and carry-out. The whole pipe moves in lock-step on
// advance, so beats stay in order and bubbles travel like data.
module rd_adder_pipe
  import rd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LEVELS = $clog2(WIDTH + 1);
  localparam int N      = WIDTH + 1;

  logic             w_advance;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_p_enc;
  logic             w_c0;
  kpg_t [N-1:0]     w_kpg_enc;
  logic [N-1:0]     w_carry;

  logic             r_valid0;
  logic [WIDTH-1:0] r_p0;
  kpg_t [N-1:0]     r_kpg0;

  logic             w_valid [0:LEVELS];
  logic [WIDTH-1:0] w_p     [0:LEVELS];
  kpg_t [N-1:0]     w_kpg   [0:LEVELS];

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  // The pipe moves whenever the output slot is empty or being drained.
  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = w_advance;

  // Operand conditioning and per-bit KPG encoding; subtract is A + ~B + 1.
  always_comb begin
    w_b_eff   = b;
    w_c0      = cin;
    w_kpg_enc = {N{KILL}};
    if (sub) begin
      w_b_eff = ~b;
      w_c0    = 1'b1;
    end else begin
      w_b_eff = b;
      w_c0    = cin;
    end
    if (w_c0) begin
      w_kpg_enc[0] = GEN;
    end else begin
      w_kpg_enc[0] = KILL;
    end
    for (int i = 0; i < WIDTH; i++) begin
      w_kpg_enc[i+1] = kpg_encode(a[i], w_b_eff[i]);
    end
    w_p_enc = a ^ w_b_eff;
  end

  // Input stage register; a bubble is captured when in_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid0 <= 1'b0;
      r_p0     <= {WIDTH{1'b0}};
      r_kpg0   <= {N{KILL}};
    end else if (w_advance) begin
      r_valid0 <= in_valid;
      r_p0     <= w_p_enc;
      r_kpg0   <= w_kpg_enc;
    end
  end

  assign w_valid[0] = r_valid0;
  assign w_p[0]     = r_p0;
  assign w_kpg[0]   = r_kpg0;

  genvar k;
  for (k = 1; k <= LEVELS; k++) begin : g_level
    rd_kpg_level #(
      .N    (N),
      .DIST (2 ** (k - 1)),
      .PW   (WIDTH)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .i_advance (w_advance),
      .i_valid   (w_valid[k-1]),
      .i_p       (w_p[k-1]),
      .i_kpg     (w_kpg[k-1]),
      .o_valid   (w_valid[k]),
      .o_p       (w_p[k]),
      .o_kpg     (w_kpg[k])
    );
  end

  // After the last level no PROP remains, so bit[1] is the carry itself.
  always_comb begin
    w_carry = {N{1'b0}};
    for (int j = 0; j < N; j++) begin
      w_carry[j] = w_kpg[LEVELS][j][1];
    end
  end

  // Output stage: sum bits and carry-out, held stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= {WIDTH{1'b0}};
      r_cout      <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= w_valid[LEVELS];
      r_sum       <= w_p[LEVELS] ^ w_carry[WIDTH-1:0];
      r_cout      <= w_carry[WIDTH];
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_rd_adder_pipe.sv
// Self-checking bench for rd_adder_pipe: a 16-bit instance exercised with
// directed and random beats against a queue-based arithmetic model, plus an
// 8-bit instance for the narrower latency case.
module tb_rd_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [15:0] a, b, sum;
  logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8;
  logic [7:0]  a8, b8, sum8;

  rd_adder_pipe #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  rd_adder_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum(sum8), .cout(cout8)
  );

  typedef struct {
    logic [16:0] val;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  bit   lat_on   = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Plain arithmetic reference: {cout, sum}.
  function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic s);
    logic [15:0] d;
    int unsigned r;
    if (s) begin
      d = x - y;
      return {(x >= y), d};
    end else begin
      r = 32'(x) + 32'(y) + 32'(ci);
      return r[16:0];
    end
  endfunction

  // One clock of the 16-bit instance: record accepts, check delivered beats.
  task automatic tick();
    exp_t e;
    #1;
    if (in_valid && in_ready) begin
      e.val = ref16(a, b, cin, sub);
      e.acc = cyc;
      e.lat = lat_on;
      sb.push_back(e);
    end
    if (out_valid && out_ready) begin
      check_val("out_beat_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_val("sum", sum, e.val[15:0]);
        check_val("cout", cout, e.val[16]);
        if (e.lat) check_val("latency", cyc - 1 - e.acc, 6);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic s);
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
  endtask

  task automatic drain(input int budget);
    in_valid = 1'b0;
    for (int i = 0; i < budget && sb.size() > 0; i++) tick();
    check_val("drain_empty", sb.size(), 0);
  endtask

  logic [15:0] h_sum;
  logic        h_cout, h_valid;
  int          n8;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = 8'h0; b8 = 8'h0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
    #2;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_sum", sum, 0);
    check_val("rst_cout", cout, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid8", out_valid8, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("post_rst_in_ready", in_ready, 1);

    // Directed add with full carry ripple, then two subtracts.
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0); tick();
    drain(20);
    drive(16'h0005, 16'h0007, 1'b0, 1'b1); tick();
    drive(16'h0007, 16'h0005, 1'b1, 1'b1); tick();
    drain(20);

    // 100 back-to-back random beats with downstream always ready.
    for (int i = 0; i < 100; i++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      check_val("rand_in_ready", in_ready, 1);
      tick();
    end

    // Stall: downstream blocks for 10 cycles while input keeps offering.
    foreach (sb[i]) sb[i].lat = 1'b0;
    lat_on = 1'b0;
    out_ready = 1'b0;
    h_valid = 1'b0; h_sum = 16'h0; h_cout = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      #1;
      check_val("stall_in_ready", in_ready, !out_valid);
      if (h_valid) begin
        check_val("stall_valid_stable", out_valid, 1);
        check_val("stall_sum_stable", sum, h_sum);
        check_val("stall_cout_stable", cout, h_cout);
      end
      h_valid = out_valid; h_sum = sum; h_cout = cout;
      tick();
    end
    check_val("stall_full_in_ready", in_ready, 0);
    check_val("stall_full_out_valid", out_valid, 1);
    out_ready = 1'b1;
    drain(50);
    for (int i = 0; i < 3; i++) begin
      check_val("no_dup", out_valid, 0);
      tick();
    end

    // Reset with three beats in flight.
    lat_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_sum", sum, 0);
    check_val("midrst_in_ready", in_ready, 1);
    sb.delete();
    @(posedge clk); cyc++; #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_val("post_rst_idle", out_valid, 0);
      tick();
    end
    drive(16'h1234, 16'h0FED, 1'b1, 1'b0); tick();
    drain(20);

    // 8-bit instance: 0x80 + 0x7F + 1 wraps to zero with carry, latency 5.
    a8 = 8'h80; b8 = 8'h7F; cin8 = 1'b1; sub8 = 1'b0; in_valid8 = 1'b1;
    #1;
    check_val("w8_in_ready", in_ready8, 1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    n8 = 0;
    while (!out_valid8 && n8 < 20) begin
      @(posedge clk); #1;
      n8++;
    end
    check_val("w8_latency", n8, 5);
    check_val("w8_sum", sum8, 8'h00);
    check_val("w8_cout", cout8, 1);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    n8 = 0;
    while (!out_valid8 && n8 < 20) begin
      @(posedge clk); #1;
      n8++;
    end
    check_val("w8_sub_latency", n8, 5);
    check_val("w8_sub_sum", sum8, 8'hF0);
    check_val("w8_sub_cout", cout8, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
